// File: rtl/ref_axi_write_arbiter.sv
// ref_axi_write_arbiter
// Two-master round-robin arbiter onto one AXI write port. A grant is held from
// AW acceptance through the wlast beat. B responses are steered back using a
// small FIFO that records, in issue order, which master owns each burst.
module ref_axi_write_arbiter #(
  parameter int AXI_ADDR_WDTH       = 32,
  parameter int AXI_CACHE_DATA_WDTH = 512,
  parameter int OUTSTANDING_DEPTH   = 4   // power of 2, at least 2
) (
  input  logic                             clk,
  input  logic                             reset,
  // master 0: reference-picture pixel writer
  input  logic [AXI_ADDR_WDTH-1:0]         s0_awaddr,
  input  logic [7:0]                       s0_awlen,
  input  logic [2:0]                       s0_awsize,
  input  logic                             s0_awvalid,
  output logic                             s0_awready,
  input  logic [AXI_CACHE_DATA_WDTH-1:0]   s0_wdata,
  input  logic [AXI_CACHE_DATA_WDTH/8-1:0] s0_wstrb,
  input  logic                             s0_wlast,
  input  logic                             s0_wvalid,
  output logic                             s0_wready,
  output logic [1:0]                       s0_bresp,
  output logic                             s0_bvalid,
  input  logic                             s0_bready,
  // master 1: collocated-MV writer
  input  logic [AXI_ADDR_WDTH-1:0]         s1_awaddr,
  input  logic [7:0]                       s1_awlen,
  input  logic [2:0]                       s1_awsize,
  input  logic                             s1_awvalid,
  output logic                             s1_awready,
  input  logic [AXI_CACHE_DATA_WDTH-1:0]   s1_wdata,
  input  logic [AXI_CACHE_DATA_WDTH/8-1:0] s1_wstrb,
  input  logic                             s1_wlast,
  input  logic                             s1_wvalid,
  output logic                             s1_wready,
  output logic [1:0]                       s1_bresp,
  output logic                             s1_bvalid,
  input  logic                             s1_bready,
  // downstream AXI write port
  output logic [AXI_ADDR_WDTH-1:0]         m_awaddr,
  output logic [7:0]                       m_awlen,
  output logic [2:0]                       m_awsize,
  output logic                             m_awvalid,
  output logic                             m_awid,
  output logic [1:0]                       m_awburst,
  input  logic                             m_awready,
  output logic [AXI_CACHE_DATA_WDTH-1:0]   m_wdata,
  output logic [AXI_CACHE_DATA_WDTH/8-1:0] m_wstrb,
  output logic                             m_wlast,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  input  logic [1:0]                       m_bresp,
  input  logic                             m_bvalid,
  output logic                             m_bready,
  // sticky protocol error flags
  output logic                             err_wlast,
  output logic                             err_spurious_b
);

  localparam int PTR_W = $clog2(OUTSTANDING_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTSTANDING_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_grant;
  logic             r_last_grant;
  logic [7:0]       r_beat_cnt;
  logic [7:0]       r_len_q;
  logic             r_err_wlast;
  logic             r_err_spurious_b;

  logic             r_fifo [OUTSTANDING_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // granted-master selects (AW and W muxes are purely combinational)
  logic [AXI_ADDR_WDTH-1:0]         w_sel_awaddr;
  logic [7:0]                       w_sel_awlen;
  logic [2:0]                       w_sel_awsize;
  logic                             w_sel_awvalid;
  logic [AXI_CACHE_DATA_WDTH-1:0]   w_sel_wdata;
  logic [AXI_CACHE_DATA_WDTH/8-1:0] w_sel_wstrb;
  logic                             w_sel_wlast;
  logic                             w_sel_wvalid;

  logic w_in_addr;
  logic w_in_data;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_req_any;
  logic w_next_grant;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_owner;
  logic w_b_fire;
  logic w_push;
  logic w_pop;
  logic w_err_beat;

  assign w_in_addr = (r_state == ST_ADDR);
  assign w_in_data = (r_state == ST_DATA);

  assign w_sel_awaddr  = r_grant ? s1_awaddr  : s0_awaddr;
  assign w_sel_awlen   = r_grant ? s1_awlen   : s0_awlen;
  assign w_sel_awsize  = r_grant ? s1_awsize  : s0_awsize;
  assign w_sel_awvalid = r_grant ? s1_awvalid : s0_awvalid;
  assign w_sel_wdata   = r_grant ? s1_wdata   : s0_wdata;
  assign w_sel_wstrb   = r_grant ? s1_wstrb   : s0_wstrb;
  assign w_sel_wlast   = r_grant ? s1_wlast   : s0_wlast;
  assign w_sel_wvalid  = r_grant ? s1_wvalid  : s0_wvalid;

  // AW channel: only driven while in ADDR
  assign m_awaddr   = w_in_addr ? w_sel_awaddr : '0;
  assign m_awlen    = w_in_addr ? w_sel_awlen  : '0;
  assign m_awsize   = w_in_addr ? w_sel_awsize : '0;
  assign m_awvalid  = w_in_addr & w_sel_awvalid;
  assign m_awid     = 1'b0;
  assign m_awburst  = 2'b01;  // INCR
  assign s0_awready = w_in_addr & ~r_grant & m_awready;
  assign s1_awready = w_in_addr &  r_grant & m_awready;

  // W channel: only driven while in DATA
  assign m_wdata   = w_in_data ? w_sel_wdata : '0;
  assign m_wstrb   = w_in_data ? w_sel_wstrb : '0;
  assign m_wlast   = w_in_data & w_sel_wlast;
  assign m_wvalid  = w_in_data & w_sel_wvalid;
  assign s0_wready = w_in_data & ~r_grant & m_wready;
  assign s1_wready = w_in_data &  r_grant & m_wready;

  assign w_aw_fire = m_awvalid & m_awready;
  assign w_w_fire  = m_wvalid & m_wready;

  // round robin: on contention the master that did not finish last wins
  assign w_req_any    = s0_awvalid | s1_awvalid;
  assign w_next_grant = (s0_awvalid & s1_awvalid) ? ~r_last_grant : s1_awvalid;

  assign w_err_beat = w_w_fire &
                      (( w_sel_wlast & (r_beat_cnt != r_len_q)) |
                       (~w_sel_wlast & (r_beat_cnt >  r_len_q)));

  // B path: head of the owner FIFO picks the master; an empty FIFO swallows
  // any response so a misbehaving slave cannot wedge the port
  assign w_fifo_full  = (r_count == DEPTH_C);
  assign w_fifo_empty = (r_count == '0);
  assign w_owner      = r_fifo[r_rd_ptr];
  assign m_bready     = w_fifo_empty ? m_bvalid : (w_owner ? s1_bready : s0_bready);
  assign s0_bvalid    = m_bvalid & ~w_fifo_empty & ~w_owner;
  assign s1_bvalid    = m_bvalid & ~w_fifo_empty &  w_owner;
  assign s0_bresp     = m_bresp;
  assign s1_bresp     = m_bresp;
  assign w_b_fire     = m_bvalid & m_bready;
  assign w_push       = w_aw_fire;
  assign w_pop        = w_b_fire & ~w_fifo_empty;

  assign err_wlast      = r_err_wlast;
  assign err_spurious_b = r_err_spurious_b;

  // arbitration FSM: grant in IDLE, hold through AW acceptance and the W burst
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
      r_len_q      <= '0;
      r_err_wlast  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_req_any && !w_fifo_full) begin
            r_grant <= w_next_grant;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_aw_fire) begin
            r_len_q    <= w_sel_awlen;
            r_beat_cnt <= '0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_w_fire) begin
            // saturate so an over-long burst cannot wrap back into range
            if (r_beat_cnt != 8'hFF) r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_err_beat) r_err_wlast <= 1'b1;
            if (w_sel_wlast) begin
              r_last_grant <= r_grant;
              r_state      <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // owner FIFO pointers, occupancy and spurious-response flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_err_spurious_b <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_b_fire && w_fifo_empty) r_err_spurious_b <= 1'b1;
    end
  end

  // owner FIFO storage
  // NOTE: storage is not reset; entries are only read when the count says
  // they were written, so clearing them would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_grant;
  end

endmodule

// File: tb/tb_ref_axi_write_arbiter.sv
// tb_ref_axi_write_arbiter
// Directed bench for the two-master AXI write arbiter. Inputs change on the
// falling edge; outputs are checked 1 time unit later, away from the rising edge.
module tb_ref_axi_write_arbiter;

  localparam int AW = 32;
  localparam int DW = 512;
  localparam int SW = DW / 8;

  logic          clk;
  logic          reset;
  logic [AW-1:0] s0_awaddr, s1_awaddr;
  logic [7:0]    s0_awlen, s1_awlen;
  logic [2:0]    s0_awsize, s1_awsize;
  logic          s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [DW-1:0] s0_wdata, s1_wdata;
  logic [SW-1:0] s0_wstrb, s1_wstrb;
  logic          s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic [1:0]    s0_bresp, s1_bresp;
  logic          s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic          m_awvalid, m_awid, m_awready;
  logic [1:0]    m_awburst;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_wlast, m_wvalid, m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid, m_bready;
  logic          err_wlast, err_spurious_b;

  int n_cmp = 0;
  int n_mis = 0;

  ref_axi_write_arbiter #(
    .AXI_ADDR_WDTH(AW), .AXI_CACHE_DATA_WDTH(DW), .OUTSTANDING_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awburst(m_awburst),
    .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .err_wlast(err_wlast), .err_spurious_b(err_spurious_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic src;

    reset = 1'b1;
    s0_awaddr = '0; s0_awlen = '0; s0_awsize = 3'd6; s0_awvalid = 1'b0;
    s1_awaddr = '0; s1_awlen = '0; s1_awsize = 3'd6; s1_awvalid = 1'b0;
    s0_wdata = '0; s0_wstrb = '1; s0_wlast = 1'b0; s0_wvalid = 1'b0;
    s1_wdata = '0; s1_wstrb = '1; s1_wlast = 1'b0; s1_wvalid = 1'b0;
    s0_bready = 1'b0; s1_bready = 1'b0;
    m_awready = 1'b1; m_wready = 1'b1; m_bresp = 2'b00; m_bvalid = 1'b0;

    // ---- reset state
    @(negedge clk); #1;
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_m_wvalid", m_wvalid, 0);
    check("rst_m_bready", m_bready, 0);
    check("rst_s0_awready", s0_awready, 0);
    check("rst_s1_wready", s1_wready, 0);
    check("rst_err", {err_wlast, err_spurious_b}, 0);
    check("rst_awburst", m_awburst, 2'b01);
    check("rst_awid", m_awid, 0);
    reset = 1'b0;

    // ---- s0 single 2-beat burst
    @(negedge clk);
    s0_awvalid = 1'b1; s0_awaddr = 32'h1000; s0_awlen = 8'd1; #1;
    check("t1_idle_awvalid", m_awvalid, 0);
    @(negedge clk); #1;
    check("t1_awvalid", m_awvalid, 1);
    check("t1_awaddr", m_awaddr, 32'h1000);
    check("t1_awlen", m_awlen, 1);
    check("t1_s0_awready", s0_awready, 1);
    check("t1_s1_awready", s1_awready, 0);
    @(negedge clk);
    s0_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wdata = 512'hA0; s0_wlast = 1'b0; #1;
    check("t1_b0_wvalid", m_wvalid, 1);
    check("t1_b0_wdata", m_wdata[63:0], 64'hA0);
    check("t1_b0_wlast", m_wlast, 0);
    check("t1_b0_s0_wready", s0_wready, 1);
    check("t1_b0_s1_wready", s1_wready, 0);
    check("t1_b0_awvalid", m_awvalid, 0);
    @(negedge clk);
    s0_wdata = 512'hA1; s0_wlast = 1'b1; #1;
    check("t1_b1_wdata", m_wdata[63:0], 64'hA1);
    check("t1_b1_wlast", m_wlast, 1);
    @(negedge clk);
    s0_wvalid = 1'b0; s0_wlast = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b10; s0_bready = 1'b1; #1;
    check("t1_idle_wvalid", m_wvalid, 0);
    check("t1_idle_s0_wready", s0_wready, 0);
    check("t1_s0_bvalid", s0_bvalid, 1);
    check("t1_s1_bvalid", s1_bvalid, 0);
    check("t1_m_bready", m_bready, 1);
    check("t1_s0_bresp", s0_bresp, 2'b10);
    @(negedge clk);
    m_bvalid = 1'b0; s0_bready = 1'b0; #1;
    check("t1_s0_bvalid_off", s0_bvalid, 0);
    check("t1_err", {err_wlast, err_spurious_b}, 0);

    // ---- both masters request continuously, awlen=0; last winner was s0
    @(negedge clk);
    s0_awvalid = 1'b1; s0_awaddr = 32'h2000; s0_awlen = 8'd0;
    s1_awvalid = 1'b1; s1_awaddr = 32'h3000; s1_awlen = 8'd0;
    s0_wvalid = 1'b1; s0_wdata = 512'hB0; s0_wlast = 1'b1;
    s1_wvalid = 1'b1; s1_wdata = 512'hC0; s1_wlast = 1'b1; #1;
    check("t2_idle_wvalid", m_wvalid, 0);
    check("t2_idle_s0_wready", s0_wready, 0);
    for (int k = 0; k < 4; k++) begin
      src = (k % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk); #1;
      check("t2_awvalid", m_awvalid, 1);
      check("t2_awaddr", m_awaddr, src ? 32'h3000 : 32'h2000);
      check("t2_s0_awready", s0_awready, !src);
      check("t2_s1_awready", s1_awready, src);
      @(negedge clk); #1;
      check("t2_wvalid", m_wvalid, 1);
      check("t2_wdata", m_wdata[63:0], src ? 64'hC0 : 64'hB0);
      check("t2_wlast", m_wlast, 1);
      check("t2_data_awvalid", m_awvalid, 0);
      @(negedge clk); #1;
      check("t2_gap_awvalid", m_awvalid, 0);
    end

    // ---- four bursts outstanding: the fifth request is held off
    @(negedge clk); #1;
    check("t3_full_awvalid", m_awvalid, 0);
    @(negedge clk);
    m_bvalid = 1'b1; m_bresp = 2'b00; s0_bready = 1'b1; s1_bready = 1'b1; #1;
    check("t3_head_s1_bvalid", s1_bvalid, 1);
    check("t3_head_s0_bvalid", s0_bvalid, 0);
    check("t3_m_bready", m_bready, 1);
    check("t3_full_awvalid2", m_awvalid, 0);
    @(negedge clk);
    m_bvalid = 1'b0; #1;
    check("t3_grant_cycle_awvalid", m_awvalid, 0);
    @(negedge clk); #1;
    check("t3_regrant_awvalid", m_awvalid, 1);
    check("t3_regrant_awaddr", m_awaddr, 32'h3000);
    @(negedge clk);
    s0_awvalid = 1'b0; s1_awvalid = 1'b0; #1;
    check("t3_wdata", m_wdata[63:0], 64'hC0);
    check("t3_s1_wready", s1_wready, 1);

    // ---- B owners now [s0,s1,s0,s1]; s1 holds bready low for 3 cycles
    @(negedge clk);
    s0_wvalid = 1'b0; s1_wvalid = 1'b0; s0_wlast = 1'b0; s1_wlast = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b01; s0_bready = 1'b1; s1_bready = 1'b0; #1;
    check("t4_idle_wvalid", m_wvalid, 0);
    check("t4_r0_s0_bvalid", s0_bvalid, 1);
    check("t4_r0_s1_bvalid", s1_bvalid, 0);
    check("t4_r0_m_bready", m_bready, 1);
    check("t4_r0_s0_bresp", s0_bresp, 2'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("t4_stall_s1_bvalid", s1_bvalid, 1);
      check("t4_stall_s0_bvalid", s0_bvalid, 0);
      check("t4_stall_m_bready", m_bready, 0);
    end
    @(negedge clk);
    s1_bready = 1'b1; #1;
    check("t4_r1_s1_bvalid", s1_bvalid, 1);
    check("t4_r1_m_bready", m_bready, 1);
    @(negedge clk); #1;
    check("t4_r2_s0_bvalid", s0_bvalid, 1);
    check("t4_r2_s1_bvalid", s1_bvalid, 0);
    @(negedge clk); #1;
    check("t4_r3_s1_bvalid", s1_bvalid, 1);
    check("t4_r3_m_bready", m_bready, 1);
    @(negedge clk); #1;
    check("t4_empty_s0_bvalid", s0_bvalid, 0);
    check("t4_empty_s1_bvalid", s1_bvalid, 0);
    check("t4_empty_m_bready", m_bready, 1);
    check("t4_spurious_pre", err_spurious_b, 0);
    @(negedge clk);
    m_bvalid = 1'b0; s0_bready = 1'b0; s1_bready = 1'b0; #1;
    check("t4_spurious_set", err_spurious_b, 1);
    check("t4_m_bready_off", m_bready, 0);

    // ---- s1 ends an awlen=3 burst early, on beat 2
    @(negedge clk);
    s1_awvalid = 1'b1; s1_awaddr = 32'h4000; s1_awlen = 8'd3;
    @(negedge clk); #1;
    check("t5_awvalid", m_awvalid, 1);
    check("t5_awlen", m_awlen, 3);
    check("t5_s1_awready", s1_awready, 1);
    @(negedge clk);
    s1_awvalid = 1'b0; s1_wvalid = 1'b1; s1_wdata = 512'hD0; s1_wlast = 1'b0; #1;
    check("t5_s1_wready", s1_wready, 1);
    check("t5_s0_wready", s0_wready, 0);
    @(negedge clk);
    s1_wdata = 512'hD1; s1_wlast = 1'b1; #1;
    check("t5_err_pre", err_wlast, 0);
    check("t5_wlast", m_wlast, 1);
    @(negedge clk);
    s1_wvalid = 1'b0; s1_wlast = 1'b0; #1;
    check("t5_err_set", err_wlast, 1);
    check("t5_idle_wvalid", m_wvalid, 0);
    s0_awvalid = 1'b1; s0_awaddr = 32'h5000; s0_awlen = 8'd0;
    @(negedge clk); #1;
    check("t5_next_awaddr", m_awaddr, 32'h5000);
    check("t5_next_s0_awready", s0_awready, 1);
    @(negedge clk);
    s0_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wdata = 512'hE0; s0_wlast = 1'b1; #1;
    check("t5_next_wdata", m_wdata[63:0], 64'hE0);
    check("t5_next_s0_wready", s0_wready, 1);
    @(negedge clk);
    s0_wvalid = 1'b0; s0_wlast = 1'b0; #1;
    check("t5_err_sticky", err_wlast, 1);

    // ---- reset asserted mid-DATA
    @(negedge clk);
    s0_awvalid = 1'b1; s0_awaddr = 32'h6000; s0_awlen = 8'd1;
    @(negedge clk); #1;
    check("t6_awvalid", m_awvalid, 1);
    @(negedge clk);
    s0_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wdata = 512'hF0; s0_wlast = 1'b0; #1;
    check("t6_pre_wvalid", m_wvalid, 1);
    reset = 1'b1; #1;
    check("t6_rst_wvalid", m_wvalid, 0);
    check("t6_rst_s0_wready", s0_wready, 0);
    check("t6_rst_awvalid", m_awvalid, 0);
    check("t6_rst_err", {err_wlast, err_spurious_b}, 0);
    @(negedge clk);
    reset = 1'b0; s0_wvalid = 1'b0;
    s0_awvalid = 1'b1; s0_awaddr = 32'h7000; s0_awlen = 8'd0;
    s1_awvalid = 1'b1; s1_awaddr = 32'h8000; s1_awlen = 8'd0;
    @(negedge clk); #1;
    check("t6_first_awaddr", m_awaddr, 32'h7000);
    check("t6_first_s0_awready", s0_awready, 1);
    check("t6_first_s1_awready", s1_awready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
